// File: rtl/bootrom_fetch.sv
// -----------------------------------------------------------------------------
// bootrom_fetch
//
// Instruction fetch front-end sitting directly behind the boot ROM. It owns the
// program counter, drives the ROM byte address, captures the ROM's registered
// read data one cycle later and hands one 32-bit instruction per fetch to
// decode through a 2-entry valid/ready queue. A redirect (branch or trap)
// flushes everything and restarts fetch at a new PC. A PC that is misaligned or
// runs past the end of the ROM stops fetching and, once the pipeline has
// drained, raises a sticky fault that only a redirect or reset clears.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   rom_addr        ROM byte address, low bits of the current PC
//   rom_rdata       ROM read data, valid the cycle after rom_addr
//   redirect_valid  load redirect_pc and flush all fetch state
//   redirect_pc     redirect target
//   inst_valid      instruction available at the queue head
//   inst_ready      decode accepts the head this cycle
//   inst            instruction word at the queue head
//   inst_pc         PC of inst, or the faulting PC while fetch_fault is high
//   fetch_fault     sticky misaligned / out-of-ROM fault
// -----------------------------------------------------------------------------
module bootrom_fetch #(
   parameter  int                XLEN            = 64,
   parameter  int                BROM_SIZE_BYTES = 4096,
   parameter  logic [XLEN-1:0]   RESET_VECTOR    = '0,
   localparam int                ADDRWIDTH       = $clog2(BROM_SIZE_BYTES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDRWIDTH-1:0]  rom_addr,
   input  logic [XLEN-1:0]       rom_rdata,
   input  logic                  redirect_valid,
   input  logic [XLEN-1:0]       redirect_pc,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [31:0]           inst,
   output logic [XLEN-1:0]       inst_pc,
   output logic                  fetch_fault
);

   // Fetch state
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] inflight_pc_q;
   logic            inflight_q;
   logic            fault_q;

   // Two-entry output queue; entry 0 is always the head
   logic [1:0]      count_q;
   logic [31:0]     head_inst_q;
   logic [XLEN-1:0] head_pc_q;
   logic [31:0]     tail_inst_q;
   logic [XLEN-1:0] tail_pc_q;

   // Combinational control
   logic [XLEN:0]   pc_end;
   logic            pc_legal;
   logic            pop;
   logic            push;
   logic [2:0]      occupancy;
   logic            issue;

   // Only the low word of the ROM read data carries the instruction; the rest
   // of the bus is deliberately ignored.
   logic [XLEN-1:0] unused_rdata;
   assign unused_rdata = rom_rdata;

   // A PC is fetchable when it is word aligned and the whole 4-byte word lies
   // inside the ROM. The end address is formed one bit wider than the PC so a
   // PC near the top of the address space cannot wrap around and look legal.
   assign pc_end   = {1'b0, pc_q} + (XLEN+1)'(4);
   assign pc_legal = (pc_q[1:0] == 2'b00) &&
                     (pc_end <= (XLEN+1)'(BROM_SIZE_BYTES));

   // The queue head is presented whenever it holds something, except while
   // faulted; in that state the port reports the offending PC instead.
   assign inst_valid  = (count_q != 2'd0) && !fault_q;
   assign inst        = head_inst_q;
   assign inst_pc     = fault_q ? pc_q : head_pc_q;
   assign fetch_fault = fault_q;
   assign rom_addr    = pc_q[ADDRWIDTH-1:0];

   // A new fetch is only launched when the queue is guaranteed to have room for
   // its response, counting what is already queued, what is in flight and what
   // decode is taking this cycle. That is what lets a response always be pushed
   // without any back-pressure on the ROM side.
   assign pop       = inst_valid && inst_ready;
   assign push      = inflight_q;
   assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue     = !redirect_valid && !fault_q && pc_legal &&
                      (occupancy < 3'd2);

   // PC and in-flight tracking. A redirect wins over everything and also drops
   // any response still in flight so stale data can never reach the queue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_VECTOR;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else if (redirect_valid) begin
         pc_q          <= redirect_pc;
         inflight_q    <= 1'b0;
      end else if (issue) begin
         pc_q          <= pc_q + XLEN'(4);
         inflight_q    <= 1'b1;
         inflight_pc_q <= pc_q;
      end else begin
         inflight_q    <= 1'b0;
      end
   end

   // Output queue. Responses land in the first free slot; a pop shifts the tail
   // into the head. When both happen together the new word goes wherever the
   // shift leaves room, so the order of instructions is always preserved.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q     <= 2'd0;
         head_inst_q <= '0;
         head_pc_q   <= '0;
         tail_inst_q <= '0;
         tail_pc_q   <= '0;
      end else if (redirect_valid) begin
         count_q     <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count_q == 2'd0) begin
                  head_inst_q <= rom_rdata[31:0];
                  head_pc_q   <= inflight_pc_q;
               end else begin
                  tail_inst_q <= rom_rdata[31:0];
                  tail_pc_q   <= inflight_pc_q;
               end
               count_q <= count_q + 2'd1;
            end
            2'b01: begin
               head_inst_q <= tail_inst_q;
               head_pc_q   <= tail_pc_q;
               count_q     <= count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  head_inst_q <= rom_rdata[31:0];
                  head_pc_q   <= inflight_pc_q;
               end else begin
                  head_inst_q <= tail_inst_q;
                  head_pc_q   <= tail_pc_q;
                  tail_inst_q <= rom_rdata[31:0];
                  tail_pc_q   <= inflight_pc_q;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Sticky fault. An illegal PC simply stops issue; the fault itself is only
   // raised once everything fetched before it has been handed to decode, so
   // valid instructions ahead of the bad PC are never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_q <= 1'b0;
      end else if (redirect_valid) begin
         fault_q <= 1'b0;
      end else if (!pc_legal && (count_q == 2'd0) && !inflight_q) begin
         fault_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bootrom_fetch.sv
// -----------------------------------------------------------------------------
// tb_bootrom_fetch
//
// Self-checking bench for bootrom_fetch (XLEN=64, 4 KiB ROM, reset vector 0).
// A small ROM model returns registered little-endian data. A cycle table covers
// start-up latency, a 5-cycle stall, a redirect and a misaligned redirect;
// hand-written sequences cover the end of the ROM and an asynchronous reset;
// a randomized phase is checked against a stream-level reference model that
// only knows which PC decode should see next.
// -----------------------------------------------------------------------------
module tb_bootrom_fetch;

   localparam int XLEN = 64;
   localparam int ROM_BYTES = 4096;
   localparam int ROM_WORDS = ROM_BYTES / 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [11:0]     rom_addr;
   logic [XLEN-1:0] rom_rdata = '0;
   logic            redirect_valid = 1'b0;
   logic [XLEN-1:0] redirect_pc = '0;
   logic            inst_valid;
   logic            inst_ready = 1'b0;
   logic [31:0]     inst;
   logic [XLEN-1:0] inst_pc;
   logic            fetch_fault;

   logic [31:0]     rom_words [ROM_WORDS];

   int vec_count = 0;
   int miscompares = 0;

   typedef struct {
      logic        ready;
      logic        redir;
      logic [63:0] rpc;
      logic        ev;
      logic [63:0] epc;
      logic        ef;
      logic [11:0] eaddr;
   } vec_t;

   vec_t tv [21];

   bootrom_fetch #(
      .XLEN(XLEN),
      .BROM_SIZE_BYTES(ROM_BYTES),
      .RESET_VECTOR(64'h0)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rom_addr(rom_addr),
      .rom_rdata(rom_rdata),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .inst_valid(inst_valid),
      .inst_ready(inst_ready),
      .inst(inst),
      .inst_pc(inst_pc),
      .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   // Registered ROM: eight bytes starting at the presented address.
   function automatic logic [63:0] romRead(logic [11:0] a);
      int idx;
      logic [31:0] hi;
      idx = int'(a[11:2]);
      hi  = (idx == ROM_WORDS - 1) ? 32'h0 : rom_words[idx + 1];
      return {hi, rom_words[idx]};
   endfunction

   always @(posedge clk) begin
      rom_rdata <= romRead(rom_addr);
   end

   function automatic logic [31:0] romWord(logic [63:0] pc);
      return rom_words[int'(pc[11:2])];
   endfunction

   // A PC is fetchable when aligned and its word ends inside the ROM.
   function automatic logic pcLegal(logic [63:0] pc);
      logic [64:0] end_addr;
      end_addr = {1'b0, pc} + 65'd4;
      return (pc[1:0] == 2'b00) && (end_addr <= 65'd4096);
   endfunction

   function automatic vec_t mk(logic r, logic rd, logic [63:0] rpc, logic ev,
                               logic [63:0] epc, logic ef, logic [11:0] ea);
      vec_t v;
      v.ready = r;   v.redir = rd; v.rpc = rpc;
      v.ev    = ev;  v.epc   = epc; v.ef = ef; v.eaddr = ea;
      return v;
   endfunction

   function automatic logic [63:0] pickTarget();
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 4)      return 64'(4 * $urandom_range(0, ROM_WORDS - 1));
      else if (sel <= 6) return 64'(ROM_BYTES - 4 * $urandom_range(1, 6));
      else if (sel == 7) return 64'(4 * $urandom_range(0, ROM_WORDS - 1) + $urandom_range(1, 3));
      else if (sel == 8) return 64'(ROM_BYTES + 4 * $urandom_range(0, 4));
      else               return 64'hFFFF_FFFF_FFFF_FFFC;
   endfunction

   task automatic applyStimulus(input logic r, input logic rd, input logic [63:0] rpc);
      inst_ready     = r;
      redirect_valid = rd;
      redirect_pc    = rpc;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      vec_count++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Random-phase model state
   logic [63:0] exp_pc;
   int          since_redir;
   int          illegal_age;
   logic        r_rdy;
   logic        r_rd;
   logic [63:0] r_pc;
   int          n_acc;
   logic        got_fault;

   initial begin
      for (int i = 0; i < ROM_WORDS; i++)
         rom_words[i] = 32'h13 | 32'(i << 20) | 32'((i & 31) << 7);

      tv[0]  = mk(1, 0, 64'h0,   0, 64'h0,   0, 12'h000);
      tv[1]  = mk(1, 0, 64'h0,   0, 64'h0,   0, 12'h004);
      tv[2]  = mk(1, 0, 64'h0,   1, 64'h0,   0, 12'h008);
      tv[3]  = mk(1, 0, 64'h0,   1, 64'h4,   0, 12'h00C);
      tv[4]  = mk(0, 0, 64'h0,   1, 64'h8,   0, 12'h010);
      tv[5]  = mk(0, 0, 64'h0,   1, 64'h8,   0, 12'h010);
      tv[6]  = mk(0, 0, 64'h0,   1, 64'h8,   0, 12'h010);
      tv[7]  = mk(0, 0, 64'h0,   1, 64'h8,   0, 12'h010);
      tv[8]  = mk(0, 0, 64'h0,   1, 64'h8,   0, 12'h010);
      tv[9]  = mk(1, 0, 64'h0,   1, 64'h8,   0, 12'h010);
      tv[10] = mk(1, 0, 64'h0,   1, 64'hC,   0, 12'h014);
      tv[11] = mk(1, 0, 64'h0,   1, 64'h10,  0, 12'h018);
      tv[12] = mk(0, 1, 64'h100, 1, 64'h14,  0, 12'h01C);
      tv[13] = mk(1, 0, 64'h0,   0, 64'h0,   0, 12'h100);
      tv[14] = mk(1, 0, 64'h0,   0, 64'h0,   0, 12'h104);
      tv[15] = mk(1, 0, 64'h0,   1, 64'h100, 0, 12'h108);
      tv[16] = mk(1, 0, 64'h0,   1, 64'h104, 0, 12'h10C);
      tv[17] = mk(1, 1, 64'h102, 1, 64'h108, 0, 12'h110);
      tv[18] = mk(1, 0, 64'h0,   0, 64'h0,   0, 12'h102);
      tv[19] = mk(1, 0, 64'h0,   0, 64'h102, 1, 12'h102);
      tv[20] = mk(0, 0, 64'h0,   0, 64'h102, 1, 12'h102);

      // Reset state
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_valid", 64'(inst_valid), 64'd0);
      checkOutput("rst_inst", 64'(inst), 64'd0);
      checkOutput("rst_pc", inst_pc, 64'd0);
      checkOutput("rst_fault", 64'(fetch_fault), 64'd0);
      checkOutput("rst_addr", 64'(rom_addr), 64'd0);

      // Cycle table: start-up, stall, redirect, misaligned redirect
      rst_n = 1'b1;
      for (int i = 0; i < 21; i++) begin
         checkOutput($sformatf("row%0d_valid", i), 64'(inst_valid), 64'(tv[i].ev));
         checkOutput($sformatf("row%0d_fault", i), 64'(fetch_fault), 64'(tv[i].ef));
         checkOutput($sformatf("row%0d_addr", i), 64'(rom_addr), 64'(tv[i].eaddr));
         if (tv[i].ev || tv[i].ef)
            checkOutput($sformatf("row%0d_pc", i), inst_pc, tv[i].epc);
         if (tv[i].ev)
            checkOutput($sformatf("row%0d_inst", i), 64'(inst), 64'(romWord(tv[i].epc)));
         applyStimulus(tv[i].ready, tv[i].redir, tv[i].rpc);
         @(negedge clk);
      end

      // Run off the end of the ROM, then recover with a redirect to 0
      applyStimulus(1, 1, 64'hFF4);
      @(negedge clk);
      applyStimulus(1, 0, 64'h0);
      n_acc = 0;
      got_fault = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (fetch_fault) begin
            got_fault = 1'b1;
            break;
         end
         if (inst_valid) begin
            checkOutput("eor_pc", inst_pc, 64'hFF4 + 64'(4 * n_acc));
            checkOutput("eor_inst", 64'(inst), 64'(romWord(64'hFF4 + 64'(4 * n_acc))));
            n_acc++;
         end
         @(negedge clk);
      end
      checkOutput("eor_fault_seen", 64'(got_fault), 64'd1);
      checkOutput("eor_count", 64'(n_acc), 64'd3);
      checkOutput("eor_fault_pc", inst_pc, 64'h1000);
      checkOutput("eor_valid", 64'(inst_valid), 64'd0);
      applyStimulus(1, 1, 64'h0);
      @(negedge clk);
      checkOutput("clr_fault", 64'(fetch_fault), 64'd0);
      checkOutput("clr_valid", 64'(inst_valid), 64'd0);
      applyStimulus(1, 0, 64'h0);
      @(negedge clk);
      checkOutput("clr_valid2", 64'(inst_valid), 64'd0);
      @(negedge clk);
      checkOutput("clr_first_valid", 64'(inst_valid), 64'd1);
      checkOutput("clr_first_pc", inst_pc, 64'h0);
      checkOutput("clr_first_inst", 64'(inst), 64'(romWord(64'h0)));
      repeat (3) @(negedge clk);

      // Asynchronous reset between clock edges while streaming
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("arst_valid", 64'(inst_valid), 64'd0);
      checkOutput("arst_inst", 64'(inst), 64'd0);
      checkOutput("arst_pc", inst_pc, 64'd0);
      checkOutput("arst_fault", 64'(fetch_fault), 64'd0);
      checkOutput("arst_addr", 64'(rom_addr), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("arst_c0_valid", 64'(inst_valid), 64'd0);
      @(negedge clk);
      checkOutput("arst_c1_valid", 64'(inst_valid), 64'd0);
      @(negedge clk);
      checkOutput("arst_c2_valid", 64'(inst_valid), 64'd1);
      checkOutput("arst_c2_pc", inst_pc, 64'h0);
      checkOutput("arst_c2_inst", 64'(inst), 64'(romWord(64'h0)));
      @(negedge clk);
      checkOutput("arst_c3_pc", inst_pc, 64'h4);

      // Randomized phase against the stream-level model
      applyStimulus(1, 1, 64'h0);
      @(negedge clk);
      exp_pc = 64'h0;
      since_redir = 0;
      illegal_age = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (pcLegal(exp_pc)) begin
            illegal_age = 0;
            checkOutput("rnd_nofault", 64'(fetch_fault), 64'd0);
            if (since_redir >= 3)
               checkOutput("rnd_live", 64'(inst_valid), 64'd1);
         end else begin
            illegal_age++;
            checkOutput("rnd_novalid", 64'(inst_valid), 64'd0);
            if (illegal_age >= 3) begin
               checkOutput("rnd_fault", 64'(fetch_fault), 64'd1);
               checkOutput("rnd_fault_pc", inst_pc, exp_pc);
            end
         end
         if (inst_valid) begin
            checkOutput("rnd_pc", inst_pc, exp_pc);
            checkOutput("rnd_inst", 64'(inst), 64'(romWord(exp_pc)));
         end
         r_rdy = ($urandom_range(0, 3) != 0);
         r_rd  = ($urandom_range(0, 15) == 0);
         r_pc  = pickTarget();
         applyStimulus(r_rdy, r_rd, r_pc);
         if (r_rd) begin
            exp_pc = r_pc;
            since_redir = 0;
            illegal_age = 0;
         end else begin
            since_redir++;
            if (inst_valid && r_rdy)
               exp_pc = exp_pc + 64'd4;
         end
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
